// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: Control state encodings, opcode field
// position, default PC step and the fetch FSM state type.
package instr_fetch_unit_pkg;

  localparam logic [3:0] S_IF       = 4'd0;
  localparam logic [3:0] S_ID       = 4'd1;
  localparam logic [3:0] S_MEM_ADR  = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC     = 4'd6;
  localparam logic [3:0] S_ALU_WB   = 4'd7;
  localparam logic [3:0] S_BRANCH3  = 4'd8;
  localparam logic [3:0] S_ADDI     = 4'd9;
  localparam logic [3:0] S_ADDI_WB  = 4'd10;
  localparam logic [3:0] S_JUMP3    = 4'd11;

  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 26;
  localparam int PC_STEP_DEF = 4;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DONE = 2'd2
  } fetch_fsm_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between fetch unit and memory.
// Handshake: a fetch completes on any rising edge where imem_req && imem_ack;
// imem_addr is held stable while imem_req is high, ack may come in the same cycle.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: increments on fetch completion, redirects take priority and
// are word aligned by clearing the two low bits.
module instr_fetch_unit_pc_reg #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= PC_RESET;
    end else if (redirect) begin
      pc <= {target[ADDR_W-1:2], 2'b00};
    end else if (inc) begin
      pc <= pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: runs the IDLE/REQ/DONE fetch FSM against instruction memory,
// holds the IR, stalls Control in IF and flags a sticky ack timeout.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int                PC_STEP  = PC_STEP_DEF,
  parameter int                TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           state,
  instr_fetch_unit_if.master   imem,
  input  logic                 pc_write,
  input  logic                 pc_write_cond,
  input  logic                 zero,
  input  logic [ADDR_W-1:0]    pc_next,
  output logic [INSTR_W-1:0]   ir,
  output logic [5:0]           opcode,
  output logic [ADDR_W-1:0]    pc,
  output logic                 ir_valid,
  output logic                 fetch_stall,
  output logic                 fetch_error,
  output fetch_fsm_t           fsm_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] T_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

  fetch_fsm_t       fsm_q, fsm_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_if;
  logic             fetch_done;

  assign in_if = (state == S_IF);
  // Request is gated by reset so an abandoned fetch drops the bus immediately.
  assign imem.imem_req  = !reset && ((fsm_q == F_REQ) || ((fsm_q == F_IDLE) && in_if));
  assign imem.imem_addr = pc;
  assign fetch_done     = imem.imem_req && imem.imem_ack;
  assign fetch_stall    = in_if && (fsm_q != F_DONE) && !fetch_done;
  assign opcode         = ir[INSTR_W-1 -: 6];
  assign fsm_state      = fsm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q <= F_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      F_IDLE:  if (in_if) fsm_d = fetch_done ? F_DONE : F_REQ;
      F_REQ:   if (fetch_done) fsm_d = F_DONE;
      F_DONE:  if (!in_if) fsm_d = F_IDLE;
      default: fsm_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir          <= '0;
      ir_valid    <= 1'b0;
      wait_cnt    <= '0;
      fetch_error <= 1'b0;
    end else if (fetch_done) begin
      ir       <= imem.imem_rdata;
      ir_valid <= 1'b1;
      wait_cnt <= '0;
    end else if (fsm_q == F_REQ) begin
      // Counter saturates; the error stays set and the request stays up.
      if (wait_cnt != T_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt >= T_LAST) fetch_error <= 1'b1;
    end
  end

  instr_fetch_unit_pc_reg #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (PC_RESET),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .inc      (fetch_done),
    .redirect (pc_write || (pc_write_cond && zero)),
    .target   (pc_next),
    .pc       (pc)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized fetch/redirect
// sequences against a transaction-level model of PC and IR.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic        pc_write, pc_write_cond, zero;
  logic [15:0] pc_next;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic [15:0] pc;
  logic        ir_valid, fetch_stall, fetch_error;
  fetch_fsm_t  fsm_state;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic        m_valid;

  instr_fetch_unit_if #(.ADDR_W(16), .INSTR_W(32)) imem_bus ();

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .state         (state),
    .imem          (imem_bus),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .zero          (zero),
    .pc_next       (pc_next),
    .ir            (ir),
    .opcode        (opcode),
    .pc            (pc),
    .ir_valid      (ir_valid),
    .fetch_stall   (fetch_stall),
    .fetch_error   (fetch_error),
    .fsm_state     (fsm_state)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    state               = S_ID;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;
    pc_write            = 1'b0;
    pc_write_cond       = 1'b0;
    zero                = 1'b0;
    pc_next             = '0;
  endtask

  // One instruction fetch: ack on the (waits+1)-th request cycle, optional
  // unconditional redirect on the completing edge.
  task automatic do_fetch(input logic [31:0] data, input int waits,
                          input bit redir, input logic [15:0] tgt);
    state = S_IF;
    imem_bus.imem_rdata = data;
    for (int i = 0; i <= waits; i++) begin
      imem_bus.imem_ack = (i == waits);
      pc_write = redir && (i == waits);
      pc_next  = tgt;
      #3;
      checks++;
      if (imem_bus.imem_req !== 1'b1) begin
        failures++; $display("FAIL fetch_req cyc=%0d got=%b exp=1", i, imem_bus.imem_req);
      end
      checks++;
      if (imem_bus.imem_addr !== m_pc) begin
        failures++; $display("FAIL fetch_addr cyc=%0d got=%h exp=%h", i, imem_bus.imem_addr, m_pc);
      end
      checks++;
      if (fetch_stall !== (i != waits)) begin
        failures++; $display("FAIL fetch_stall cyc=%0d got=%b exp=%b", i, fetch_stall, (i != waits));
      end
      checks++;
      if (ir !== m_ir) begin
        failures++; $display("FAIL ir_hold cyc=%0d got=%h exp=%h", i, ir, m_ir);
      end
      step();
    end
    idle_inputs();
    m_ir    = data;
    m_valid = 1'b1;
    m_pc    = redir ? {tgt[15:2], 2'b00} : m_pc + 16'd4;
    checks++;
    if (ir !== m_ir || opcode !== m_ir[31:26] || ir_valid !== 1'b1) begin
      failures++; $display("FAIL fetch_ir got=%h/%h/%b exp=%h/%h/1", ir, opcode, ir_valid, m_ir, m_ir[31:26]);
    end
    checks++;
    if (pc !== m_pc) begin
      failures++; $display("FAIL fetch_pc got=%h exp=%h", pc, m_pc);
    end
    step();
  endtask

  // Redirect while Control is outside IF; applies only if taken.
  task automatic do_branch(input bit uncond, input bit cond, input bit z,
                           input logic [15:0] tgt);
    pc_write      = uncond;
    pc_write_cond = cond;
    zero          = z;
    pc_next       = tgt;
    step();
    idle_inputs();
    if (uncond || (cond && z)) m_pc = tgt & 16'hFFFC;
    checks++;
    if (pc !== m_pc) begin
      failures++; $display("FAIL branch_pc got=%h exp=%h", pc, m_pc);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    state = S_IF;
    reset = 1'b1;
    step();
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b0) begin
      failures++; $display("FAIL reset_req got=%b exp=0", imem_bus.imem_req);
    end
    checks++;
    if (pc !== 16'h0000 || ir !== 32'h0 || ir_valid !== 1'b0 || fetch_error !== 1'b0) begin
      failures++; $display("FAIL reset_state got=%h/%h/%b/%b exp=0000/00000000/0/0", pc, ir, ir_valid, fetch_error);
    end
    state = S_ID;
    step();
    reset = 1'b0;
    m_pc = 16'h0000; m_ir = '0; m_valid = 1'b0;
    step();
  endtask

  task automatic test_zero_wait();
    do_fetch(32'h2002_0005, 0, 1'b0, 16'h0);
    checks++;
    if (opcode !== 6'h08 || pc !== 16'h0004) begin
      failures++; $display("FAIL zero_wait got=%h/%h exp=08/0004", opcode, pc);
    end
  endtask

  task automatic test_three_wait();
    do_fetch($urandom, 3, 1'b0, 16'h0);
    checks++;
    if (pc !== 16'h0008) begin
      failures++; $display("FAIL three_wait_pc got=%h exp=0008", pc);
    end
  endtask

  task automatic test_branch();
    do_branch(1'b0, 1'b1, 1'b1, 16'h0043);
    checks++;
    if (pc !== 16'h0040) begin
      failures++; $display("FAIL branch_taken got=%h exp=0040", pc);
    end
    do_branch(1'b0, 1'b1, 1'b0, 16'h0080);
    checks++;
    if (pc !== 16'h0040) begin
      failures++; $display("FAIL branch_not_taken got=%h exp=0040", pc);
    end
  endtask

  task automatic test_redirect_fetch();
    do_branch(1'b1, 1'b0, 1'b0, 16'h0010);
    do_fetch(32'hA5A5_1234, 0, 1'b1, 16'h0100);
    checks++;
    if (pc !== 16'h0100 || ir !== 32'hA5A5_1234) begin
      failures++; $display("FAIL redirect_fetch got=%h/%h exp=0100/a5a51234", pc, ir);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      do_fetch($urandom, $urandom_range(0, 5), ($urandom_range(0, 3) == 0),
               16'($urandom));
      if ($urandom_range(0, 1) == 1)
        do_branch(($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 1), 16'($urandom));
    end
  endtask

  task automatic test_wrap();
    do_branch(1'b1, 1'b0, 1'b0, 16'hFFFC);
    do_fetch(32'h0C00_0001, 1, 1'b0, 16'h0);
    checks++;
    if (pc !== 16'h0000) begin
      failures++; $display("FAIL wrap_pc got=%h exp=0000", pc);
    end
  endtask

  task automatic test_timeout();
    state = S_IF;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (fetch_error !== 1'b0) begin
      failures++; $display("FAIL timeout_early got=%b exp=0", fetch_error);
    end
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (fetch_error !== 1'b1 || imem_bus.imem_req !== 1'b1 || fetch_stall !== 1'b1) begin
      failures++; $display("FAIL timeout_set got=%b/%b/%b exp=1/1/1", fetch_error, imem_bus.imem_req, fetch_stall);
    end
    imem_bus.imem_rdata = 32'h1234_5678;
    imem_bus.imem_ack   = 1'b1;
    step();
    idle_inputs();
    m_ir = 32'h1234_5678; m_valid = 1'b1; m_pc = m_pc + 16'd4;
    step();
    checks++;
    if (fetch_error !== 1'b1 || ir !== m_ir || pc !== m_pc) begin
      failures++; $display("FAIL timeout_sticky got=%b/%h/%h exp=1/%h/%h", fetch_error, ir, pc, m_ir, m_pc);
    end
  endtask

  task automatic test_reset_mid_req();
    state = S_IF;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    #1;
    checks++;
    if (imem_bus.imem_req !== 1'b0 || pc !== 16'h0000 || ir_valid !== 1'b0 || fsm_state !== F_IDLE) begin
      failures++; $display("FAIL reset_mid_req got=%b/%h/%b/%0d exp=0/0000/0/0", imem_bus.imem_req, pc, ir_valid, fsm_state);
    end
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    imem_bus.imem_ack   = 1'b1;
    step();
    state = S_ID;
    reset = 1'b0;
    step();
    step();
    checks++;
    if (ir !== 32'h0 || ir_valid !== 1'b0 || pc !== 16'h0000 || fetch_error !== 1'b0) begin
      failures++; $display("FAIL reset_ack_ignored got=%h/%b/%h/%b exp=00000000/0/0000/0", ir, ir_valid, pc, fetch_error);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_three_wait();
    test_branch();
    test_redirect_fetch();
    test_random();
    test_wrap();
    test_timeout();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream neighbour of the multicycle Control FSM. Owns the PC and instruction register (IR) and fetches from instruction memory over a req/ack handshake while Control sits in IF. It presents opcode = IR[31:26] to Control and stalls Control while memory has not responded. It also applies PC redirects for jumps and taken branches from the datapath.

Parameters:
ADDR_W, 16, PC/instruction-address width
INSTR_W, 32, instruction width; opcode is the top 6 bits
PC_RESET, 0, PC value after reset
PC_STEP, 4, PC increment per completed fetch
TIMEOUT, 15, max wait cycles for imem_ack before fetch_error sets

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
state  in  4  current Control state; IF = 0
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address, equal to pc
imem_rdata  in  INSTR_W  instruction data, valid when imem_ack = 1
imem_ack  in  1  memory response; may arrive in the same cycle as imem_req
pc_write  in  1  unconditional PC load (JUMP3)
pc_write_cond  in  1  conditional PC load (BRANCH3)
zero  in  1  ALU zero flag, qualifies pc_write_cond
pc_next  in  ADDR_W  redirect target
ir  out  INSTR_W  instruction register
opcode  out  6  ir[INSTR_W-1 -: 6], to Control
pc  out  ADDR_W  program counter
ir_valid  out  1  IR holds a fetched instruction
fetch_stall  out  1  Control must hold in IF
fetch_error  out  1  sticky timeout flag

Behaviour:
- Reset (async, immediate): pc = PC_RESET, ir = 0, ir_valid = 0, fetch_error = 0, imem_req = 0, wait counter = 0, FSM = IDLE. A fetch in progress when reset asserts is abandoned. An ack arriving during or after reset is ignored.
- FSM has three states: IDLE, REQ, DONE.
  - IDLE -> REQ: when state == IF.
  - REQ -> DONE: on imem_ack.
  - DONE -> IDLE: when state != IF.
- imem_req = 1 while in REQ. It is also 1 in IDLE when state == IF, so a zero-wait memory can complete a fetch in one cycle.
- imem_addr = pc, stable while imem_req = 1.
- On a clock edge with imem_req && imem_ack:
  - ir <= imem_rdata, ir_valid <= 1
  - pc <= pc + PC_STEP, wrapping modulo 2^ADDR_W
  - wait counter <= 0
- fetch_stall = (state == IF) && (FSM != DONE) && !(imem_req && imem_ack). This output is combinational.
- Latency: a fetch takes 1 + N cycles for N wait cycles. With a zero-wait memory, the one-cycle IF path is unchanged.
- IR and opcode stay stable from fetch completion until the next fetch completes.
- Redirect: on an edge with pc_write || (pc_write_cond && zero):
  - pc <= {pc_next[ADDR_W-1:2], 2'b00}; the low two bits are forced to 0.
  - A redirect coinciding with a fetch completion wins over the increment; ir is still loaded.
- An ack outside IDLE-with-IF or REQ is ignored.
- Wait counter increments each REQ cycle without ack. When it reaches TIMEOUT, fetch_error sets and stays set until reset. The request stays asserted after the timeout.
- If state leaves IF while in REQ (Control misbehaving), the FSM stays in REQ until ack.

Decomposition:
- Shared package/header (extends the existing opcodes include): Control state encodings (IF = 0 through JUMP3 = 11), OPCODE_MSB/LSB, PC_STEP default.
- One natural sub-module: pc_reg, covering PC register, increment, redirect priority and alignment.
- The FSM and IR stay in the top level.

Test Plan:
1. Zero-wait fetch: state = 0 for 1 cycle, ack in the same cycle, rdata = 0x2002_0005 -> ir = 0x20020005, opcode = 0x08, pc 0 -> 4, fetch_stall = 0 throughout.
2. Three-wait fetch: ack on the 4th req cycle -> fetch_stall = 1 for 3 cycles then 0, imem_addr held at 4, pc -> 8, exactly one IR load.
3. Branch: pc_write_cond = 1 with zero = 1 and pc_next = 0x0043 -> pc = 0x0040; repeated with zero = 0 -> pc unchanged.
4. Simultaneous redirect and fetch ack: pc_write = 1, pc_next = 0x0100, pc = 0x0010 -> pc = 0x0100, not 0x0014; ir is loaded.
5. Wrap and timeout: pc = 0xFFFC fetch -> pc = 0x0000; withhold ack 15 cycles -> fetch_error = 1 and stays 1 after a later ack.
6. Reset mid-REQ: reset while waiting, then ack -> imem_req = 0 immediately, pc = 0, ir_valid = 0, no IR load.
